alu_seq_nbit: RTL and testbench

//  Registered, parametrised ALU; successor to the 3-bit combinational CPU ALU. Sits between

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_iter.sv | 48 ++++
 rtl/alu_seq_nbit.sv | 168 ++++++++++++++++
 tb/tb_alu_seq_nbit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state types and the SF/ZF flag helper for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SHL = 3'b010,
    OP_SHR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  localparam int unsigned FLAG_MAX_W = 64;

  // {SF, ZF} of a result zero-extended to FLAG_MAX_W bits; w is the real result width.
  function automatic logic [1:0] alu_flags_f(input logic [FLAG_MAX_W-1:0] r,
                                             input int unsigned           w);
    logic [FLAG_MAX_W-1:0] sh;
    sh = r >> (w - 32'd1);
    return {sh[0], ~|r};
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: consumes one multiplier bit per i_run cycle.
// o_done_c is high in the last of WIDTH run cycles, with o_prod_c holding the full product.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_run,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done_c,
  output logic [2*WIDTH-1:0]   o_prod_c
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_addend;

  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign o_prod_c = r_acc + w_addend;
  assign o_done_c = i_run & (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
    end else if (i_run) begin
      r_acc    <= o_prod_c;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with valid/ready handshake on both sides.
// Define ALU_MUL_EN to build the iterative multiplier for OP=111; otherwise OP=111 yields zero.
module alu_seq_nbit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             CF,
  output logic             SF,
  output logic             ZF,
  output logic             OF,
  output logic             busy
);

  localparam int unsigned      SHAMT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_LIM   = WIDTH'(WIDTH);

  logic               w_accept, w_accept_1c, w_idle;
  logic [WIDTH:0]     w_sum, w_dif, w_shl, w_shr;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_sh_over;
  logic [WIDTH-1:0]   w_res;
  logic               w_res_cf, w_res_of;

  logic               r_out_valid, r_cf, r_sf, r_zf, r_of;
  logic [WIDTH-1:0]   r_r;
  logic               w_ov_nxt, w_cf_nxt, w_of_nxt;
  logic [WIDTH-1:0]   w_r_nxt;
  logic [1:0]         w_sz_nxt;

  assign w_sum     = {1'b0, A} + {1'b0, B};
  assign w_dif     = {1'b0, A} - {1'b0, B};
  assign w_shamt   = B[SHAMT_W-1:0];
  // Any shift distance of WIDTH or more (judged on all of B) clears both R and CF.
  assign w_sh_over = (B >= W_LIM);
  assign w_shl     = {1'b0, A} << w_shamt;
  assign w_shr     = {A, 1'b0} >> w_shamt;

  // Single-cycle result and carry/overflow.
  always_comb begin
    w_res    = '0;
    w_res_cf = 1'b0;
    w_res_of = 1'b0;
    case (OP)
      OP_ADD: begin
        w_res    = w_sum[WIDTH-1:0];
        w_res_cf = w_sum[WIDTH];
        w_res_of = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res    = w_dif[WIDTH-1:0];
        w_res_cf = w_dif[WIDTH];
        w_res_of = (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SHL: if (!w_sh_over) begin
        w_res    = w_shl[WIDTH-1:0];
        w_res_cf = w_shl[WIDTH];
      end
      OP_SHR: if (!w_sh_over) begin
        w_res    = w_shr[WIDTH:1];
        w_res_cf = w_shr[0];
      end
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_t         r_state, w_state_nxt;
  logic               w_mul_start, w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_mul_start = w_accept && (OP == OP_MUL);
  assign w_accept_1c = w_accept && (OP != OP_MUL);
  assign busy        = (r_state == ST_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mul_start),
    .i_run    (busy),
    .i_a      (A),
    .i_b      (B),
    .o_done_c (w_mul_done),
    .o_prod_c (w_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end
`else
  assign w_idle      = 1'b1;
  assign w_accept_1c = w_accept;
  assign busy        = 1'b0;
`endif

  assign in_ready = w_idle & (~r_out_valid | out_ready) & ~rst;
  assign w_accept = in_valid & in_ready;

  // Next state and next output register contents.
  always_comb begin
`ifdef ALU_MUL_EN
    w_state_nxt = r_state;
`endif
    w_ov_nxt = r_out_valid & ~out_ready;
    w_r_nxt  = r_r;
    w_cf_nxt = r_cf;
    w_of_nxt = r_of;
    if (w_accept_1c) begin
      w_ov_nxt = 1'b1;
      w_r_nxt  = w_res;
      w_cf_nxt = w_res_cf;
      w_of_nxt = w_res_of;
    end
`ifdef ALU_MUL_EN
    if (w_mul_start) w_state_nxt = ST_MUL;
    if (w_mul_done) begin
      w_state_nxt = ST_IDLE;
      w_ov_nxt    = 1'b1;
      w_r_nxt     = w_prod[WIDTH-1:0];
      w_cf_nxt    = |w_prod[2*WIDTH-1:WIDTH];
      w_of_nxt    = |w_prod[2*WIDTH-1:WIDTH];
    end
`endif
  end

  assign w_sz_nxt = alu_flags_f(FLAG_MAX_W'(w_r_nxt), WIDTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_r         <= '0;
      r_cf        <= 1'b0;
      r_sf        <= 1'b0;
      r_zf        <= 1'b1;
      r_of        <= 1'b0;
    end else begin
      r_out_valid <= w_ov_nxt;
      r_r         <= w_r_nxt;
      r_cf        <= w_cf_nxt;
      r_sf        <= w_sz_nxt[1];
      r_zf        <= w_sz_nxt[0];
      r_of        <= w_of_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign R         = r_r;
  assign CF        = r_cf;
  assign SF        = r_sf;
  assign ZF        = r_zf;
  assign OF        = r_of;

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Scoreboard bench for alu_seq_nbit: arithmetic reference model, random and directed stimulus.
// Build with or without ALU_MUL_EN; expectations follow the same macro.
module tb_alu_seq_nbit;

  localparam int unsigned W = 8;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT  = W + 1;
  localparam int BUSY_EXP = W;
`else
  localparam int MUL_LAT  = 1;
  localparam int BUSY_EXP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         CF, SF, ZF, OF, busy;
  logic [W-1:0] A, B, R;
  logic [2:0]   OP;

  typedef struct {
    logic [W-1:0] r;
    logic         cf, sf, zf, of;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   or_mode  = 0;   // 0: always ready, 1: random, 2: stalled

  alu_seq_nbit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .OP(OP), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .CF(CF), .SF(SF), .ZF(ZF), .OF(OF), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned/signed interpretations.
  function automatic exp_t model(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                 input logic [2:0] op);
    exp_t   e;
    longint a = a_in;
    longint b = b_in;
    longint wl = W;
    longint full = longint'(1) << W;
    longint half = full / 2;
    longint sa, sbv, ss, rr;
    bit     cf, of;
    sa  = (a >= half) ? a - full : a;
    sbv = (b >= half) ? b - full : b;
    rr  = 0; cf = 1'b0; of = 1'b0;
    case (op)
      3'd0: begin
        rr = (a + b) % full; cf = (a + b) >= full;
        ss = sa + sbv;       of = (ss >= half) || (ss < -half);
      end
      3'd1: begin
        rr = (a - b + full) % full; cf = a < b;
        ss = sa - sbv;              of = (ss >= half) || (ss < -half);
      end
      3'd2: if (b < wl) begin
        rr = (a << b) % full;
        if (b != 0) cf = ((a >> (wl - b)) & 1) != 0;
      end
      3'd3: if (b < wl) begin
        rr = a >> b;
        if (b != 0) cf = ((a >> (b - 1)) & 1) != 0;
      end
      3'd4: rr = a & b;
      3'd5: rr = a | b;
      3'd6: rr = a ^ b;
      default: begin
`ifdef ALU_MUL_EN
        rr = (a * b) % full; cf = (a * b) >= full; of = cf;
`endif
      end
    endcase
    e.r   = rr[W-1:0];
    e.cf  = cf;
    e.of  = of;
    e.sf  = rr >= half;
    e.zf  = rr == 0;
    e.cyc = 0;
    return e;
  endfunction

  // Consumer side: out_ready changes just after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks each new result (value and arrival cycle) and stability while stalled.
  initial begin : monitor
    exp_t         e;
    logic         prev_stall;
    logic [W-1:0] h_r;
    logic [3:0]   h_fl;
    prev_stall = 1'b0;
    h_r = '0; h_fl = '0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_R", R, h_r);
          check("hold_flags", {CF, SF, ZF, OF}, h_fl);
        end
        if (out_valid && !prev_stall) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: R=0x%0h with nothing expected (cycle %0d)", R, cyc);
          end else begin
            e = sb[0];
            check("R", R, e.r);
            check("CF", CF, e.cf);
            check("SF", SF, e.sf);
            check("ZF", ZF, e.zf);
            check("OF", OF, e.of);
            check("latency_cycle", cyc, e.cyc);
          end
        end
        if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
        prev_stall = out_valid && !out_ready;
        h_r  = R;
        h_fl = {CF, SF, ZF, OF};
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    A = a; B = b; OP = op; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b, want 1 within 200 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      e = model(a, b, op);
      e.cyc = cyc + ((op == 3'd7) ? MUL_LAT : 1);
      sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  logic [W-1:0] d_a  [13] = '{8'h03, 8'hFF, 8'h7F, 8'h10, 8'h80, 8'h81, 8'h81,
                              8'h81, 8'h81, 8'h81, 8'h81, 8'hA5, 8'h00};
  logic [W-1:0] d_b  [13] = '{8'h05, 8'h01, 8'h01, 8'h20, 8'h01, 8'h01, 8'h08,
                              8'h00, 8'h08, 8'h07, 8'h07, 8'h0F, 8'h00};
  logic [2:0]   d_op [13] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3,
                              3'd3, 3'd2, 3'd3, 3'd2, 3'd6, 3'd1};

  initial begin
    int busy_cnt, t;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; OP = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_R", R, 0);
    check("rst_flags", {CF, SF, ZF, OF}, 4'b0010);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;

    // Directed arithmetic and shift boundaries.
    for (int i = 0; i < 13; i++) issue(d_a[i], d_b[i], d_op[i]);
    drain();

    // Four back-to-back ops, then a stalled consumer with a pending op.
    issue(W'($urandom), W'($urandom), 3'd4);
    issue(W'($urandom), W'($urandom), 3'd5);
    issue(W'($urandom), W'($urandom), 3'd6);
    issue(W'($urandom), W'($urandom), 3'd0);
    drain();
    or_mode = 2;
    repeat (2) @(posedge clk);
    issue(8'h3C, 8'h0F, 3'd4);
    fork
      issue(8'h12, 8'h34, 3'd0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
        end
        or_mode = 0;
      end
    join
    drain();

    // MUL: busy duration and refusal of input while busy.
    issue(8'h10, 8'h11, 3'd7);
    busy_cnt = 0; t = 0;
    while (t < 50) begin
      @(negedge clk);
      t++;
      if (out_valid) break;
      if (busy) begin
        busy_cnt++;
        check("busy_in_ready", in_ready, 0);
        A = 8'h01; B = 8'h01; OP = 3'd0; in_valid = 1'b1;
      end
    end
    in_valid = 1'b0;
    check("busy_cycles", busy_cnt, BUSY_EXP);
    drain();

`ifdef ALU_MUL_EN
    // Reset in the middle of a multiply aborts it.
    issue(8'hFF, 8'hFF, 3'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_R", R, 0);
    check("abort_flags", {CF, SF, ZF, OF}, 4'b0010);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    rst = 1'b0;
    repeat (W + 3) begin
      @(negedge clk);
      check("abort_no_result", out_valid, 0);
    end
`endif

    // Random traffic with a randomly stalling consumer.
    or_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, W + 1));
      issue(ra, rb, 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    or_mode = 0;
    drain();
    repeat (3) @(negedge clk);
    check("final_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
